cp0_regfile: RTL and testbench
==============================

# cp0_regfile

Coprocessor-0 register file and exception state holder: the responder side of the writeback-stage CP0 interface. Serves MFC0 reads, commits MTC0 writes, records exception entry (EPC, Cause, BadVAddr, Status.EXL), clears EXL on ERET, runs the Count/Compare timer and produces the pending-interrupt request sampled by the pipeline. Sits beside the writeback stage; its `epc` output feeds the fetch-stage redirect on ERET.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `resetn`  in  1  synchronous, active-low reset
- `c0_we`  in  1  MTC0 commit strobe
- `c0_addr`  in  8  register select `{rd[4:0], sel[2:0]}`
- `c0_wdata`  in  32 (`uint32_t`)  MTC0 data
- `c0_rdata`  out  32 (`uint32_t`)  MFC0 data, combinational from `c0_addr`
- `c0_eret_flush`  in  1  ERET committed this cycle
- `c0_exception`  in  `exception_t`  `{bd, ex, exccode[4:0], badvaddr[31:0]}`; `ex` = exception commits this cycle
- `c0_pc`  in  `virt_t`  PC of the committing instruction
- `ext_int`  in  6  hardware interrupt lines, level-sensitive, already synchronous to `clk`
- `epc`  out  `virt_t`  current EPC, ERET target
- `int_pending`  out  1  interrupt request to pipeline

## Operation
- Implemented registers (addr `{rd,sel}`): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0). Other addresses: read 0, writes ignored.
- Status: bit22 BEV read-only 1; IM[15:8] RW; EXL bit1 RW; IE bit0 RW; all other bits read 0.
- Cause: BD bit31 RO; TI bit30 RO; IP[15:10] RO = `{TI | ext_int[5], ext_int[4:0]}` sampled each cycle; IP[9:8] RW; ExcCode[6:2] RO; others 0.
- EPC, BadVAddr: 32-bit; EPC RW, BadVAddr RO.
- Exception entry (`c0_exception.ex`=1): if Status.EXL=0: EPC ← `bd ? c0_pc-4 : c0_pc` (mod 2^32), Cause.BD ← bd. Regardless of EXL: Status.EXL ← 1, Cause.ExcCode ← exccode. BadVAddr ← badvaddr only when exccode ∈ {AdEL=0x04, AdES=0x05}.
- ERET (`c0_eret_flush`=1, ex=0): Status.EXL ← 0.
- Priority in one cycle: `ex` > `c0_eret_flush` > `c0_we`. With `ex`=1 the MTC0 write is dropped entirely.
- `int_pending` = `|(Cause.IP[15:8] & Status.IM[15:8]) & Status.IE & ~Status.EXL`, combinational from register state.

## Timing
- Reset (`resetn`=0 at rising edge): Status=0x0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0; hence `c0_rdata` for Status reads 0x0040_0000, `epc`=0, `int_pending`=0.
- All register updates take effect at the rising edge after the strobe; `c0_rdata` is zero-latency from current state (MTC0 followed by MFC0 next cycle returns new value; same-cycle read returns old value).
- Count increments by 1 every second cycle (1-bit tick toggles each cycle; increment when tick=1); wraps 0xFFFF_FFFF→0.
- TI set on the edge after Count==Compare (held compare); cleared only by MTC0 Compare.
- MTC0 Count wins over increment in that cycle; tick not reset by the write.
- MTC0 Compare in the same cycle as Count==Compare: TI ends 0.
- Reset mid-operation discards any in-flight strobe.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare and TI as above.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, Cause.IP7 = `ext_int[5]` only; no tick/counter flops.

## Structure
- Shared `cpu.svh` package: CP0 address constants (`C0_BADVADDR`…`C0_EPC` as 8-bit `{rd,sel}`), ExcCode constants (`EXC_INT`, `EXC_ADEL`, `EXC_ADES`, …), `cp0_status_t` and `cp0_cause_t` packed structs; existing `uint32_t`, `virt_t`, `exception_t`.
- One sub-module: `cp0_timer` (tick, Count, Compare, TI; write ports for Count/Compare), instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset then read 12,0 / 13,0 / 14,0 → 0x0040_0000 / 0 / 0; `int_pending`=0.
- MTC0 Status=0x0000_FF03 (all bits) → read 0x0040_FF03; MTC0 Status=0x0000_FF01 with `ext_int[2]`=1 → `int_pending`=1 next cycle.
- Exception ex=1, bd=1, exccode=0x04, pc=0xBFC0_0104, badvaddr=0x1234_5679 → EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1234_5679, EXL=1; second exception exccode=0x0A, pc=0x8000_0000 → EPC unchanged, ExcCode=0x0A, BadVAddr unchanged.
- ERET with EXL=1 → EXL=0; ERET + ex same cycle → EXL=1; MTC0 EPC + ex same cycle → EPC from exception.
- (`CP0_TIMER_EN`) MTC0 Compare=5, Count=0 → TI=1 after Count reaches 5 (~11 cycles); MTC0 Compare=100 → TI=0; Count=0xFFFF_FFFF wraps to 0 after two cycles.
- (no `CP0_TIMER_EN`) MTC0 Count=7 → read 0; TI never set.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 types, register addresses and exception codes.
// Used by cp0_regfile, cp0_timer and cp0_regfile_if.
package cp0_regfile_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic       bd;
        logic       ex;
        logic [4:0] exccode;
        virt_t      badvaddr;
    } exception_t;

    // Addresses are {rd[4:0], sel[2:0]}.
    localparam logic [7:0] C0_BADVADDR = 8'h40;
    localparam logic [7:0] C0_COUNT    = 8'h48;
    localparam logic [7:0] C0_COMPARE  = 8'h58;
    localparam logic [7:0] C0_STATUS   = 8'h60;
    localparam logic [7:0] C0_CAUSE    = 8'h68;
    localparam logic [7:0] C0_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic [8:0] zero0;
        logic       bev;
        logic [5:0] zero1;
        logic [7:0] im;
        logic [5:0] zero2;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero0;
        logic [7:0]  ip;
        logic        zero1;
        logic [4:0]  exccode;
        logic [1:0]  zero2;
    } cp0_cause_t;

endpackage

// File: rtl/cp0_regfile_if.sv
// Writeback-stage CP0 interface: pipeline is master, cp0_regfile is slave.
interface cp0_regfile_if;
    import cp0_regfile_pkg::*;

    logic       c0_we;
    logic [7:0] c0_addr;
    uint32_t    c0_wdata;
    uint32_t    c0_rdata;
    logic       c0_eret_flush;
    exception_t c0_exception;
    virt_t      c0_pc;
    virt_t      epc;
    logic       int_pending;

    modport master (
        output c0_we, c0_addr, c0_wdata, c0_eret_flush, c0_exception, c0_pc,
        input  c0_rdata, epc, int_pending
    );

    modport slave (
        input  c0_we, c0_addr, c0_wdata, c0_eret_flush, c0_exception, c0_pc,
        output c0_rdata, epc, int_pending
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on match.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_regfile_pkg::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    count_we,
    input  logic    compare_we,
    input  uint32_t wdata,
    output uint32_t count,
    output uint32_t compare,
    output logic    ti
);

    logic    tick_q, tick_d;
    uint32_t count_q, count_d;
    uint32_t compare_q, compare_d;
    logic    ti_q, ti_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'b0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q;
        // A software Count write overrides the increment but leaves the tick phase alone.
        if (count_we) count_d = wdata;
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr, exception entry, ERET, interrupt request.
// Define CP0_TIMER_EN to include the Count/Compare timer (cp0_timer).
module cp0_regfile
    import cp0_regfile_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    cp0_regfile_if.slave   bus,
    input  logic [5:0]     ext_int
);

    logic [7:0] status_im_q, status_im_d;
    logic       status_exl_q, status_exl_d;
    logic       status_ie_q, status_ie_d;
    logic       cause_bd_q, cause_bd_d;
    logic [7:0] cause_ip_q, cause_ip_d;
    logic [4:0] cause_exccode_q, cause_exccode_d;
    virt_t      epc_q, epc_d;
    virt_t      badvaddr_q, badvaddr_d;

    exception_t exc;
    logic       we_go;
    logic       ti;
    uint32_t    count_val;
    uint32_t    compare_val;

    assign exc   = bus.c0_exception;
    assign we_go = bus.c0_we & ~exc.ex & ~bus.c0_eret_flush;

`ifdef CP0_TIMER_EN
    logic count_we;
    logic compare_we;

    assign count_we   = we_go && (bus.c0_addr == C0_COUNT);
    assign compare_we = we_go && (bus.c0_addr == C0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.c0_wdata),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (ti)
    );
`else
    assign ti          = 1'b0;
    assign count_val   = '0;
    assign compare_val = '0;
`endif

    always_comb begin
        status_im_d     = status_im_q;
        status_exl_d    = status_exl_q;
        status_ie_d     = status_ie_q;
        cause_bd_d      = cause_bd_q;
        cause_ip_d      = cause_ip_q;
        cause_exccode_d = cause_exccode_q;
        epc_d           = epc_q;
        badvaddr_d      = badvaddr_q;

        cause_ip_d[7:2] = {ti | ext_int[5], ext_int[4:0]};

        if (exc.ex) begin
            // Nested exceptions keep the original EPC/BD so the outer handler can return.
            if (!status_exl_q) begin
                epc_d      = exc.bd ? (bus.c0_pc - 32'd4) : bus.c0_pc;
                cause_bd_d = exc.bd;
            end
            status_exl_d    = 1'b1;
            cause_exccode_d = exc.exccode;
            if (exc.exccode == EXC_ADEL || exc.exccode == EXC_ADES)
                badvaddr_d = exc.badvaddr;
        end else if (bus.c0_eret_flush) begin
            status_exl_d = 1'b0;
        end else if (we_go) begin
            case (bus.c0_addr)
                C0_STATUS: begin
                    status_im_d  = bus.c0_wdata[15:8];
                    status_exl_d = bus.c0_wdata[1];
                    status_ie_d  = bus.c0_wdata[0];
                end
                C0_CAUSE: cause_ip_d[1:0] = bus.c0_wdata[9:8];
                C0_EPC:   epc_d = bus.c0_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_im_q     <= '0;
            status_exl_q    <= 1'b0;
            status_ie_q     <= 1'b0;
            cause_bd_q      <= 1'b0;
            cause_ip_q      <= '0;
            cause_exccode_q <= '0;
            epc_q           <= '0;
            badvaddr_q      <= '0;
        end else begin
            status_im_q     <= status_im_d;
            status_exl_q    <= status_exl_d;
            status_ie_q     <= status_ie_d;
            cause_bd_q      <= cause_bd_d;
            cause_ip_q      <= cause_ip_d;
            cause_exccode_q <= cause_exccode_d;
            epc_q           <= epc_d;
            badvaddr_q      <= badvaddr_d;
        end
    end

    cp0_status_t status_rd;
    cp0_cause_t  cause_rd;

    always_comb begin
        status_rd     = '0;
        status_rd.bev = 1'b1;
        status_rd.im  = status_im_q;
        status_rd.exl = status_exl_q;
        status_rd.ie  = status_ie_q;

        cause_rd         = '0;
        cause_rd.bd      = cause_bd_q;
        cause_rd.ti      = ti;
        cause_rd.ip      = cause_ip_q;
        cause_rd.exccode = cause_exccode_q;

        case (bus.c0_addr)
            C0_BADVADDR: bus.c0_rdata = badvaddr_q;
            C0_COUNT:    bus.c0_rdata = count_val;
            C0_COMPARE:  bus.c0_rdata = compare_val;
            C0_STATUS:   bus.c0_rdata = status_rd;
            C0_CAUSE:    bus.c0_rdata = cause_rd;
            C0_EPC:      bus.c0_rdata = epc_q;
            default:     bus.c0_rdata = '0;
        endcase
    end

    assign bus.epc         = epc_q;
    assign bus.int_pending = (|(cause_ip_q & status_im_q)) & status_ie_q & ~status_exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: table-driven MTC0/MFC0 vectors plus
// hand-written exception, ERET, interrupt, timer and reset sequences.
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] ext_int;

    always #5 clk = ~clk;

    cp0_regfile_if bus();

    cp0_regfile dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .ext_int (ext_int)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string name, input logic [7:0] addr, input logic [31:0] exp);
        sb_t e;
        bus.c0_addr = addr;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        check(e.name, bus.c0_rdata, e.exp);
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        bus.c0_we    = 1'b1;
        bus.c0_addr  = addr;
        bus.c0_wdata = data;
        cyc();
        bus.c0_we    = 1'b0;
    endtask

    task automatic set_ex(input logic bd, input logic [4:0] code, input logic [31:0] pc,
                          input logic [31:0] bva);
        bus.c0_exception.ex       = 1'b1;
        bus.c0_exception.bd       = bd;
        bus.c0_exception.exccode  = code;
        bus.c0_exception.badvaddr = bva;
        bus.c0_pc                 = pc;
    endtask

    task automatic clr_strobes();
        bus.c0_exception.ex = 1'b0;
        bus.c0_eret_flush   = 1'b0;
        bus.c0_we           = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;

        vecs[0] = '{"status_all",  C0_STATUS,   32'h0000_FF03, C0_STATUS,   32'h0040_FF03};
        vecs[1] = '{"status_ro",   C0_STATUS,   32'hFFFF_FFFF, C0_STATUS,   32'h0040_FF03};
        vecs[2] = '{"status_clr",  C0_STATUS,   32'h0000_0000, C0_STATUS,   32'h0040_0000};
        vecs[3] = '{"cause_ro",    C0_CAUSE,    32'hFFFF_FFFF, C0_CAUSE,    32'h0000_0300};
        vecs[4] = '{"cause_clr",   C0_CAUSE,    32'h0000_0000, C0_CAUSE,    32'h0000_0000};
        vecs[5] = '{"epc_rw",      C0_EPC,      32'hDEAD_BEEF, C0_EPC,      32'hDEAD_BEEF};
        vecs[6] = '{"badvaddr_ro", C0_BADVADDR, 32'h0000_5555, C0_BADVADDR, 32'h0000_0000};
        vecs[7] = '{"unimpl_addr", 8'h01,       32'h1234_5678, 8'h01,       32'h0000_0000};

        resetn        = 1'b0;
        ext_int       = '0;
        bus.c0_we     = 1'b0;
        bus.c0_addr   = '0;
        bus.c0_wdata  = '0;
        bus.c0_eret_flush = 1'b0;
        bus.c0_exception  = '0;
        bus.c0_pc     = '0;
        repeat (3) cyc();

        expect_rd("rst_status",   C0_STATUS,   32'h0040_0000);
        expect_rd("rst_cause",    C0_CAUSE,    32'h0000_0000);
        expect_rd("rst_epc",      C0_EPC,      32'h0000_0000);
        expect_rd("rst_badvaddr", C0_BADVADDR, 32'h0000_0000);
        check("rst_epc_port", bus.epc, 32'h0);
        check("rst_int_pending", {31'b0, bus.int_pending}, 32'h0);

        // Park Compare far away on the first live cycle so TI stays clear.
        resetn = 1'b1;
        mtc0(C0_COMPARE, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            mtc0(vecs[i].waddr, vecs[i].wdata);
            expect_rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Same-cycle read returns old value.
        bus.c0_we    = 1'b1;
        bus.c0_addr  = C0_EPC;
        bus.c0_wdata = 32'h0000_1111;
        #2;
        check("epc_same_cycle_old", bus.c0_rdata, 32'hDEAD_BEEF);
        cyc();
        bus.c0_we = 1'b0;
        expect_rd("epc_next_cycle_new", C0_EPC, 32'h0000_1111);

        // Hardware and software interrupts.
        ext_int = 6'b000100;
        mtc0(C0_STATUS, 32'h0000_FF01);
        cyc();
        check("int_hw_pending", {31'b0, bus.int_pending}, 32'h1);
        expect_rd("cause_ip_hw", C0_CAUSE, 32'h0000_1000);
        ext_int = '0;
        cyc();
        cyc();
        check("int_hw_released", {31'b0, bus.int_pending}, 32'h0);
        mtc0(C0_CAUSE, 32'h0000_0200);
        check("int_sw_pending", {31'b0, bus.int_pending}, 32'h1);
        mtc0(C0_STATUS, 32'h0000_0001);
        check("int_masked", {31'b0, bus.int_pending}, 32'h0);
        mtc0(C0_STATUS, 32'h0000_FF01);
        mtc0(C0_CAUSE, 32'h0000_0000);
        check("int_sw_cleared", {31'b0, bus.int_pending}, 32'h0);

        // Exception in delay slot, AdEL.
        set_ex(1'b1, EXC_ADEL, 32'hBFC0_0104, 32'h1234_5679);
        cyc();
        clr_strobes();
        check("ex1_epc", bus.epc, 32'hBFC0_0100);
        expect_rd("ex1_cause", C0_CAUSE, 32'h8000_0010);
        expect_rd("ex1_badvaddr", C0_BADVADDR, 32'h1234_5679);
        expect_rd("ex1_status", C0_STATUS, 32'h0040_FF03);
        check("ex1_int_blocked", {31'b0, bus.int_pending}, 32'h0);

        // Nested exception with EXL already set.
        set_ex(1'b0, EXC_RI, 32'h8000_0000, 32'hAAAA_5555);
        cyc();
        clr_strobes();
        check("ex2_epc_kept", bus.epc, 32'hBFC0_0100);
        expect_rd("ex2_cause", C0_CAUSE, 32'h8000_0028);
        expect_rd("ex2_badvaddr_kept", C0_BADVADDR, 32'h1234_5679);

        bus.c0_eret_flush = 1'b1;
        cyc();
        clr_strobes();
        expect_rd("eret_status", C0_STATUS, 32'h0040_FF01);

        // ERET and exception together: exception wins.
        bus.c0_eret_flush = 1'b1;
        set_ex(1'b0, EXC_OV, 32'h0000_0100, 32'h0);
        cyc();
        clr_strobes();
        expect_rd("eret_ex_status", C0_STATUS, 32'h0040_FF03);
        check("eret_ex_epc", bus.epc, 32'h0000_0100);
        expect_rd("eret_ex_cause", C0_CAUSE, 32'h0000_0030);

        bus.c0_eret_flush = 1'b1;
        cyc();
        clr_strobes();

        // MTC0 EPC dropped by a same-cycle exception (AdES updates BadVAddr).
        bus.c0_we    = 1'b1;
        bus.c0_addr  = C0_EPC;
        bus.c0_wdata = 32'h1111_1111;
        set_ex(1'b0, EXC_ADES, 32'h0000_2000, 32'hCAFE_F00D);
        cyc();
        clr_strobes();
        check("mtc0_ex_epc", bus.epc, 32'h0000_2000);
        expect_rd("ades_badvaddr", C0_BADVADDR, 32'hCAFE_F00D);

        bus.c0_we    = 1'b1;
        bus.c0_addr  = C0_STATUS;
        bus.c0_wdata = 32'h0000_0000;
        set_ex(1'b0, EXC_SYS, 32'h0000_3000, 32'h0);
        cyc();
        clr_strobes();
        expect_rd("mtc0_status_dropped", C0_STATUS, 32'h0040_FF03);
        check("nested_epc_kept", bus.epc, 32'h0000_2000);

`ifdef CP0_TIMER_EN
        mtc0(C0_COMPARE, 32'd5);
        mtc0(C0_COUNT, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            bus.c0_addr = C0_CAUSE;
            #2;
            if (bus.c0_rdata[30]) found = 1'b1;
            else cyc();
        end
        check("ti_set", {31'b0, found}, 32'h1);
        mtc0(C0_COMPARE, 32'd100);
        bus.c0_addr = C0_CAUSE;
        #2;
        check("ti_cleared", {31'b0, bus.c0_rdata[30]}, 32'h0);
        expect_rd("compare_rd", C0_COMPARE, 32'd100);
        mtc0(C0_COUNT, 32'hFFFF_FFFF);
        cyc();
        cyc();
        expect_rd("count_wrap", C0_COUNT, 32'h0000_0000);
`else
        mtc0(C0_COUNT, 32'd7);
        expect_rd("count_absent", C0_COUNT, 32'h0);
        mtc0(C0_COMPARE, 32'd7);
        expect_rd("compare_absent", C0_COMPARE, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.c0_addr = C0_CAUSE;
            #2;
            if (bus.c0_rdata[30]) found = 1'b1;
            cyc();
        end
        check("ti_never", {31'b0, found}, 32'h0);
`endif

        // Reset with an MTC0 in flight.
        bus.c0_we    = 1'b1;
        bus.c0_addr  = C0_STATUS;
        bus.c0_wdata = 32'h0000_FF03;
        resetn       = 1'b0;
        cyc();
        bus.c0_we = 1'b0;
        resetn    = 1'b1;
        expect_rd("midrst_status", C0_STATUS, 32'h0040_0000);
        check("midrst_epc", bus.epc, 32'h0);
        check("midrst_int_pending", {31'b0, bus.int_pending}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
